// File: rtl/branch_predictor_pkg.sv
// ============================================================================
// Module      : branch_predictor_pkg
// Description : Shared counter encodings and defaults for the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_predictor_pkg;

    localparam int          c_ENTRIES_DEFAULT = 16;

    localparam logic [1:0]  c_CTR_SN    = 2'b00;
    localparam logic [1:0]  c_CTR_WN    = 2'b01;
    localparam logic [1:0]  c_CTR_WT    = 2'b10;
    localparam logic [1:0]  c_CTR_ST    = 2'b11;

    localparam logic [1:0]  c_CTR_RESET = c_CTR_WN;
    localparam logic [1:0]  c_CTR_ALLOC = c_CTR_WT;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predictor_sat_counter2.sv
// ============================================================================
// Module      : sat_counter2
// Description : 2-bit saturating direction counter, next-state only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] next
);

    always_comb begin
        next = cur;
        if (taken) begin
            if (cur != c_CTR_ST) next = cur + 2'b01;
        end else begin
            if (cur != c_CTR_SN) next = cur - 2'b01;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit counters, zero-latency lookup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = c_ENTRIES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pred_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int IB = $clog2(ENTRIES);
    localparam int TW = 30 - IB;

    logic [ENTRIES-1:0] r_valid;
    logic [TW-1:0]      r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [31:0]        r_branch_cnt;
    logic [31:0]        r_mispred_cnt;

    logic [IB-1:0]      w_pidx;
    logic [TW-1:0]      w_ptag;
    logic               w_phit;
    logic [IB-1:0]      w_uidx;
    logic [TW-1:0]      w_utag;
    logic               w_uhit;
    logic [1:0]         w_ctr_next;

    // Lookup reads only registered state, so a same-cycle update is not visible.
    assign w_pidx      = pred_pc[IB+1:2];
    assign w_ptag      = pred_pc[31:IB+2];
    assign w_phit      = r_valid[w_pidx] && (r_tag[w_pidx] == w_ptag);
    assign pred_taken  = w_phit && r_ctr[w_pidx][1];
    assign pred_target = pred_taken ? r_target[w_pidx] : seq_pc(pred_pc);

    assign w_uidx      = upd_pc[IB+1:2];
    assign w_utag      = upd_pc[31:IB+2];
    assign w_uhit      = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    assign mispredict  = upd_valid &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

    sat_counter2 u_sat_counter2 (
        .cur   (r_ctr[w_uidx]),
        .taken (upd_taken),
        .next  (w_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= c_CTR_RESET;
            end
        end else if (upd_valid) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
            if (mispredict) r_mispred_cnt <= r_mispred_cnt + 32'd1;
            if (w_uhit) begin
                r_ctr[w_uidx] <= w_ctr_next;
            end else if (upd_taken) begin
                r_valid[w_uidx] <= 1'b1;
                r_ctr[w_uidx]   <= c_CTR_ALLOC;
            end
        end
    end

    // Tag/target carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= upd_target;
        end
    end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped table entries (power of two, 4..256).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port pred_pc, input, 32, fetch-stage PC to predict.
REQ-005 SHALL have port pred_taken, output, 1, predicted direction for pred_pc.
REQ-006 SHALL have port pred_target, output, 32, predicted next PC for pred_pc.
REQ-007 SHALL have port upd_valid, input, 1, a conditional branch resolved this cycle.
REQ-008 SHALL have port upd_pc, input, 32, PC of the resolved branch.
REQ-009 SHALL have port upd_taken, input, 1, actual direction (BranchTaken from the branch comparator).
REQ-010 SHALL have port upd_target, input, 32, actual branch target address.
REQ-011 SHALL have ports upd_pred_taken (1) and upd_pred_target (32), inputs, prediction carried down the pipe for that branch.
REQ-012 SHALL have port mispredict, output, 1, resolved branch disagreed with its prediction.
REQ-013 SHALL have ports branch_cnt and mispred_cnt, outputs, 32 each, statistics counters.

Function
REQ-014 SHALL use index = pc[IB+1:2], IB = log2(ENTRIES), and tag = pc[31:IB+2]; pc[1:0] ignored.
REQ-015 SHALL hold per entry: valid bit, tag, 32-bit target, 2-bit saturating counter (00 SN, 01 WN, 10 WT, 11 ST).
REQ-016 SHALL produce pred_taken/pred_target combinationally from registered table state in the same cycle as pred_pc (zero-cycle latency).
REQ-017 SHALL drive hit = valid[idx] && tag match; pred_taken = hit && ctr[1]; pred_target = (pred_taken) ? stored target : pred_pc + 4 (mod 2^32).
REQ-018 SHALL, on upd_valid with tag hit, increment counter on taken and decrement on not-taken, saturating at 11 and 00.
REQ-019 SHALL, on upd_valid with hit and upd_taken, overwrite the stored target with upd_target.
REQ-020 SHALL, on upd_valid with miss and upd_taken, allocate: valid=1, tag and target written, counter=10 (replaces any prior occupant).
REQ-021 SHALL, on upd_valid with miss and not taken, leave the table unchanged.
REQ-022 SHALL drive mispredict combinationally = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
REQ-023 SHALL increment branch_cnt on every upd_valid cycle and mispred_cnt on every mispredict cycle; both wrap 0xFFFFFFFF -> 0.
REQ-024 SHALL, when prediction and update address the same index in one cycle, return the pre-update entry; new value visible next cycle.
REQ-025 SHALL ignore all update inputs when upd_valid = 0.

Reset
REQ-026 SHALL, while rst = 1 at a clock edge, clear all valid bits, set all counters to 01, zero branch_cnt and mispred_cnt; targets/tags need no reset.
REQ-027 SHALL give rst priority over a concurrent upd_valid (update discarded).
REQ-028 SHALL, during and after reset, output pred_taken = 0 and pred_target = pred_pc + 4 until an entry is allocated.

Structure
REQ-029 SHALL place counter encodings (SN/WN/WT/ST), reset counter value and default ENTRIES in the shared defines.v.
REQ-030 SHALL implement the 2-bit saturating update as sub-module sat_counter2 (inputs cur, taken; output next), one combinational instance on the update path.

Verification
REQ-031 Reset then pred_pc=0x00000100 -> pred_taken=0, pred_target=0x00000104, counters 0.
REQ-032 upd_valid, upd_pc=0x100, taken, target=0x80, pred_taken=0 -> mispredict=1; next cycle pred_pc=0x100 -> pred_taken=1, pred_target=0x80; branch_cnt=1, mispred_cnt=1.
REQ-033 Three not-taken updates to 0x100 after allocation -> counter 10->01->00->00, pred_taken=0 after the first.
REQ-034 Alias: allocate 0x100 taken, then update 0x140 (same index, ENTRIES=16) taken target 0x200 -> 0x100 misses (pred_target 0x104), 0x140 predicts 0x200.
REQ-035 Same-cycle predict and allocate at 0x100 -> pred_taken=0 that cycle, 1 next cycle; rst asserted with upd_valid -> table and counters reset, update lost.
REQ-036 Force mispred_cnt to 0xFFFFFFFF, one mispredicting update -> mispred_cnt=0.
